// File: rtl/snoop_fi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_fi_pkg
//  Purpose  : Shared definitions for the snoop fault injector: rule config
//             word field offsets, test-mode encodings, the FSM state type and
//             the CD fill-width helper.
//  Revision : 1.0 - initial multi-rule release
// ============================================================================
package snoop_fi_pkg;

  // Rule configuration word field offsets
  localparam int CFG_EN      = 0;
  localparam int CFG_ONESHOT = 1;
  localparam int CFG_TEST_LO = 2;   // [3:2]
  localparam int CFG_RESP_LO = 4;   // [8:4]
  localparam int CFG_SNF_EN  = 9;
  localparam int CFG_ADF_EN  = 10;
  localparam int CFG_SNP_LO  = 11;  // [14:11]

  // Test encodings: which response signal is held back
  localparam logic [1:0] TEST_IMM = 2'b00;
  localparam logic [1:0] TEST_CRV = 2'b01;
  localparam logic [1:0] TEST_CDV = 2'b10;
  localparam logic [1:0] TEST_CDL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MATCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DELAY = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Number of 32-bit fill words needed to cover the CD data bus
  function automatic int fill_words(input int data_w);
    return data_w / 32;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_rule_match.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_rule_match
//  Purpose  : Evaluates a single injection rule against a latched snoop.
//  Ports    : i_cfg   - rule config word
//             i_base  - address window base
//             i_size  - address window size
//             i_snoop - latched acsnoop
//             i_addr  - latched acaddr[31:0]
//             i_fired - sticky fired flag of this rule
//             o_match - rule matches this snoop
//  Revision : 1.0 - initial release
// ============================================================================
module snoop_rule_match
  import snoop_fi_pkg::*;
(
  input  logic [31:0] i_cfg,
  input  logic [31:0] i_base,
  input  logic [31:0] i_size,
  input  logic [3:0]  i_snoop,
  input  logic [31:0] i_addr,
  input  logic        i_fired,
  output logic        o_match
);

  logic [32:0] w_end;
  logic        w_addr_ok;
  logic        w_snp_ok;
  logic        w_unused_cfg;

  // 33-bit end address so a window ending exactly at 2^32 does not wrap
  assign w_end     = {1'b0, i_base} + {1'b0, i_size};
  assign w_addr_ok = !i_cfg[CFG_ADF_EN] ||
                     ((i_addr >= i_base) && ({1'b0, i_addr} < w_end));
  assign w_snp_ok  = !i_cfg[CFG_SNF_EN] || (i_snoop == i_cfg[CFG_SNP_LO +: 4]);
  assign o_match   = i_cfg[CFG_EN] && !(i_cfg[CFG_ONESHOT] && i_fired) &&
                     w_addr_ok && w_snp_ok;

  // Response/test/reserved fields are consumed by the top level
  assign w_unused_cfg = &{1'b0, i_cfg[31:15], i_cfg[8:2]};

endmodule
`default_nettype wire

// File: rtl/snoop_fault_injector.sv
`default_nettype none
// ============================================================================
//  Module   : snoop_fault_injector
//  Purpose  : Multi-rule crafted CR/CD snoop responder with a programmable
//             delay on one response signal.
//  Ports    : ace_aclk/ace_areset          - clock, async active-high reset
//             i_ac_valid/acsnoop/acaddr    - snoop handover (one-cycle pulse)
//             i_rule_cfg/base/size/delay   - per-rule configuration
//             i_fill_pattern               - CD data word (replicated)
//             i_fired_clr                  - per-rule clear of o_fired
//             i_crready/i_cdready          - response handshake ready
//             o_crvalid/o_crresp           - CR channel
//             o_cdvalid/o_cdlast/o_cddata  - CD channel (single beat)
//             o_busy/o_pass/o_done         - status
//             o_hit_rule/o_fired           - last fired rule / sticky flags
//  Revision : 1.0 - initial multi-rule release
// ============================================================================
module snoop_fault_injector
  import snoop_fi_pkg::*;
#(
  parameter int C_ACE_DATA_WIDTH = 128,
  parameter int C_ACE_ADDR_WIDTH = 44,
  parameter int NUM_RULES        = 4,
  parameter int DELAY_W          = 16,
  parameter int CYCLES_PER_UNIT  = 150,
  localparam int IDX_W           = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
)(
  input  logic                          ace_aclk,
  input  logic                          ace_areset,
  input  logic                          i_ac_valid,
  input  logic [3:0]                    acsnoop,
  input  logic [C_ACE_ADDR_WIDTH-1:0]   acaddr,
  input  logic [32*NUM_RULES-1:0]       i_rule_cfg,
  input  logic [32*NUM_RULES-1:0]       i_rule_base,
  input  logic [32*NUM_RULES-1:0]       i_rule_size,
  input  logic [DELAY_W*NUM_RULES-1:0]  i_rule_delay,
  input  logic [31:0]                   i_fill_pattern,
  input  logic [NUM_RULES-1:0]          i_fired_clr,
  input  logic                          i_crready,
  input  logic                          i_cdready,
  output logic                          o_crvalid,
  output logic [4:0]                    o_crresp,
  output logic                          o_cdvalid,
  output logic                          o_cdlast,
  output logic [C_ACE_DATA_WIDTH-1:0]   o_cddata,
  output logic                          o_busy,
  output logic                          o_pass,
  output logic                          o_done,
  output logic [IDX_W-1:0]              o_hit_rule,
  output logic [NUM_RULES-1:0]          o_fired
);

  localparam int CNT_W  = DELAY_W + 8;
  localparam int FILL_N = fill_words(C_ACE_DATA_WIDTH);

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_snoop;
  logic [31:0]             r_addr;
  logic [NUM_RULES-1:0]    w_match;
  logic                    w_hit;
  logic [IDX_W-1:0]        w_hit_idx;
  logic [4:0]              w_hit_resp;
  logic [1:0]              w_hit_test;
  logic [1:0]              w_test_eff;
  logic [DELAY_W-1:0]      w_hit_delay;
  logic [IDX_W-1:0]        r_idx;
  logic [1:0]              r_test;
  logic                    r_has_data;
  logic [CNT_W-1:0]        r_n, r_cnt;
  logic                    r_cr_done, r_cd_done;
  logic                    r_crvalid, r_cdvalid, r_cdlast;
  logic [4:0]              r_crresp;
  logic [C_ACE_DATA_WIDTH-1:0] r_cddata;
  logic                    r_pass, r_done;
  logic [IDX_W-1:0]        r_hit_rule;
  logic [NUM_RULES-1:0]    r_fired;
  logic                    w_cr_hs, w_cd_hs, w_cr_cmp, w_cd_cmp;
  logic                    w_skip_dly, w_dly_end;
  logic                    w_set_cr, w_set_cd, w_set_last, w_pass, w_fin;
  logic                    w_unused_addr;

  assign w_unused_addr = &{1'b0, acaddr};

  // ---------------------------------------------------------------- rules
  for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
    snoop_rule_match u_match (
      .i_cfg   (i_rule_cfg[32*g +: 32]),
      .i_base  (i_rule_base[32*g +: 32]),
      .i_size  (i_rule_size[32*g +: 32]),
      .i_snoop (r_snoop),
      .i_addr  (r_addr),
      .i_fired (r_fired[g]),
      .o_match (w_match[g])
    );
  end

  // Lowest matching index wins: scan downwards so the last write is lowest
  always_comb begin
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_hit_resp  = '0;
    w_hit_test  = '0;
    w_hit_delay = '0;
    for (int k = NUM_RULES - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        w_hit       = 1'b1;
        w_hit_idx   = IDX_W'(k);
        w_hit_resp  = i_rule_cfg[32*k + CFG_RESP_LO +: 5];
        w_hit_test  = i_rule_cfg[32*k + CFG_TEST_LO +: 2];
        w_hit_delay = i_rule_delay[DELAY_W*k +: DELAY_W];
      end
    end
  end

  // Without a data phase there is nothing to delay on CD: fall back to immediate
  assign w_test_eff = (!w_hit_resp[0] && w_hit_test[1]) ? TEST_IMM : w_hit_test;

  // Handshake/completion terms
  assign w_cr_hs    = r_crvalid & i_crready;
  assign w_cd_hs    = r_cdvalid & r_cdlast & i_cdready;
  assign w_cr_cmp   = r_cr_done | w_cr_hs;
  assign w_cd_cmp   = r_cd_done | w_cd_hs;
  assign w_skip_dly = (r_n == '0) || (r_test == TEST_IMM);
  assign w_dly_end  = (r_cnt == r_n - CNT_W'(1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge ace_aclk or posedge ace_areset) begin
    if (ace_areset) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_ac_valid) w_state_nxt = ST_MATCH;
      ST_MATCH: w_state_nxt = w_hit ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_state_nxt = w_skip_dly ? ST_HOLD : ST_DELAY;
      ST_DELAY: if (w_dly_end) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_cr_cmp && w_cd_cmp) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: which response signals to raise this cycle
  always_comb begin
    logic w_issue;
    logic w_dly_now;
    w_issue    = (r_state == ST_ISSUE);
    // The delayed signal rises at ISSUE when there is no delay, else at the
    // last DELAY cycle
    w_dly_now  = (w_issue && w_skip_dly) || ((r_state == ST_DELAY) && w_dly_end);
    w_set_cr   = (w_issue && (r_test != TEST_CRV)) ||
                 (w_dly_now && (r_test == TEST_CRV));
    w_set_cd   = r_has_data &&
                 ((w_issue && (r_test != TEST_CDV)) ||
                  (w_dly_now && (r_test == TEST_CDV)));
    w_set_last = r_has_data &&
                 ((w_issue && !r_test[1]) || (w_dly_now && r_test[1]));
    w_pass     = (r_state == ST_MATCH) && !w_hit;
    w_fin      = (r_state == ST_DONE);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge ace_aclk or posedge ace_areset) begin
    if (ace_areset) begin
      r_snoop    <= '0;
      r_addr     <= '0;
      r_idx      <= '0;
      r_test     <= '0;
      r_has_data <= 1'b0;
      r_n        <= '0;
      r_cnt      <= '0;
      r_cr_done  <= 1'b0;
      r_cd_done  <= 1'b0;
      r_crvalid  <= 1'b0;
      r_cdvalid  <= 1'b0;
      r_cdlast   <= 1'b0;
      r_crresp   <= '0;
      r_cddata   <= '0;
      r_pass     <= 1'b0;
      r_done     <= 1'b0;
      r_hit_rule <= '0;
      r_fired    <= '0;
    end else begin
      r_pass <= w_pass;
      r_done <= w_fin;

      if ((r_state == ST_IDLE) && i_ac_valid) begin
        r_snoop <= acsnoop;
        r_addr  <= acaddr[31:0];
      end

      // Config is captured only here; later changes do not affect this response
      if ((r_state == ST_MATCH) && w_hit) begin
        r_idx      <= w_hit_idx;
        r_test     <= w_test_eff;
        r_has_data <= w_hit_resp[0];
        r_crresp   <= w_hit_resp;
        r_n        <= CNT_W'(CYCLES_PER_UNIT) * CNT_W'(w_hit_delay);
        r_cddata   <= {FILL_N{i_fill_pattern}};
        r_cr_done  <= 1'b0;
        r_cd_done  <= !w_hit_resp[0];
      end else begin
        if (w_cr_hs) r_cr_done <= 1'b1;
        if (w_cd_hs) r_cd_done <= 1'b1;
      end

      r_cnt <= (r_state == ST_DELAY) ? r_cnt + CNT_W'(1) : '0;

      if (w_fin)         r_crvalid <= 1'b0;
      else if (w_set_cr) r_crvalid <= 1'b1;
      else if (w_cr_hs)  r_crvalid <= 1'b0;

      if (w_fin)         r_cdvalid <= 1'b0;
      else if (w_set_cd) r_cdvalid <= 1'b1;
      else if (w_cd_hs)  r_cdvalid <= 1'b0;

      if (w_fin)           r_cdlast <= 1'b0;
      else if (w_set_last) r_cdlast <= 1'b1;
      else if (w_cd_hs)    r_cdlast <= 1'b0;

      if (w_fin) r_hit_rule <= r_idx;

      // A set from DONE wins over a same-cycle clear
      r_fired <= (r_fired & ~i_fired_clr) |
                 (w_fin ? (NUM_RULES'(1) << r_idx) : '0);
    end
  end

  assign o_crvalid  = r_crvalid;
  assign o_crresp   = r_crresp;
  assign o_cdvalid  = r_cdvalid;
  assign o_cdlast   = r_cdlast;
  assign o_cddata   = r_cddata;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_pass     = r_pass;
  assign o_done     = r_done;
  assign o_hit_rule = r_hit_rule;
  assign o_fired    = r_fired;

endmodule
`default_nettype wire

// File: tb/tb_snoop_fault_injector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_snoop_fault_injector
//  Purpose  : Self-checking bench for snoop_fault_injector (vector table,
//             response scoreboard, hand-written multi-cycle sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_fault_injector;

  localparam int DW = 128, AW = 44, NR = 4, DLW = 16, CPU = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              ac_valid = 0;
  logic [3:0]        snoop = 0;
  logic [AW-1:0]     addr = 0;
  logic [32*NR-1:0]  cfg = 0, base = 0, size = 0;
  logic [DLW*NR-1:0] dly = 0;
  logic [31:0]       fill = 32'hA5C3_0F1E;
  logic [NR-1:0]     fclr = 0;
  logic              crready = 0, cdready = 0;
  logic              o_crvalid, o_cdvalid, o_cdlast, o_busy, o_pass, o_done;
  logic [4:0]        o_crresp;
  logic [DW-1:0]     o_cddata;
  logic [1:0]        o_hit_rule;
  logic [NR-1:0]     o_fired;

  snoop_fault_injector #(
    .C_ACE_DATA_WIDTH(DW), .C_ACE_ADDR_WIDTH(AW), .NUM_RULES(NR),
    .DELAY_W(DLW), .CYCLES_PER_UNIT(CPU)
  ) dut (
    .ace_aclk(clk), .ace_areset(rst), .i_ac_valid(ac_valid),
    .acsnoop(snoop), .acaddr(addr), .i_rule_cfg(cfg), .i_rule_base(base),
    .i_rule_size(size), .i_rule_delay(dly), .i_fill_pattern(fill),
    .i_fired_clr(fclr), .i_crready(crready), .i_cdready(cdready),
    .o_crvalid(o_crvalid), .o_crresp(o_crresp), .o_cdvalid(o_cdvalid),
    .o_cdlast(o_cdlast), .o_cddata(o_cddata), .o_busy(o_busy),
    .o_pass(o_pass), .o_done(o_done), .o_hit_rule(o_hit_rule), .o_fired(o_fired)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(bit en, bit os, logic [1:0] t, logic [4:0] r,
                                     bit snf, bit adf, logic [3:0] sv);
    logic [31:0] w;
    w = '0;
    w[0] = en; w[1] = os; w[3:2] = t; w[8:4] = r;
    w[9] = snf; w[10] = adf; w[14:11] = sv;
    return w;
  endfunction

  // ------------------------------------------------------------ scoreboard
  typedef struct { bit pass; int hit; logic [4:0] resp; } sb_t;
  sb_t sbq[$];
  sb_t sb_e;

  always @(posedge clk) begin
    #1;
    if (!rst && (o_pass || o_done)) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", {o_pass, o_done}, 2'b00);
      end else begin
        sb_e = sbq.pop_front();
        chk("sb_kind", {o_pass, o_done}, sb_e.pass ? 2'b10 : 2'b01);
        if (!sb_e.pass) begin
          chk("sb_hit", o_hit_rule, sb_e.hit);
          chk("sb_resp", o_crresp, sb_e.resp);
        end
      end
    end
  end

  // ------------------------------------------------------------ vectors
  typedef struct {
    string        nm;
    bit           clr;
    logic [127:0] cfg, base, size;
    logic [63:0]  dly;
    logic [3:0]   snoop;
    logic [43:0]  addr;
    bit           pass;
    int           hit;
    logic [4:0]   resp;
    logic [1:0]   test;
    int           n;
    logic [3:0]   fired;
  } vec_t;
  vec_t vt[$];

  task automatic addv(string nm, bit clr, logic [127:0] c, logic [127:0] b,
                      logic [127:0] s, logic [63:0] d, logic [3:0] sn, logic [43:0] a,
                      bit pass, int hit, logic [4:0] resp, logic [1:0] test, int n,
                      logic [3:0] fired);
    vec_t v;
    v.nm = nm; v.clr = clr; v.cfg = c; v.base = b; v.size = s; v.dly = d;
    v.snoop = sn; v.addr = a; v.pass = pass; v.hit = hit; v.resp = resp;
    v.test = test; v.n = n; v.fired = fired;
    vt.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int t_cr, t_cd, t_last, t_pass, t_done, e_cr, e_cd, e_last, mx;
    logic [1:0] te;
    sb_t s;
    cfg = v.cfg; base = v.base; size = v.size; dly = v.dly;
    crready = 1; cdready = 1;
    if (v.clr) fclr = '1;
    @(posedge clk); #1;
    fclr = '0;
    s.pass = v.pass; s.hit = v.hit; s.resp = v.resp;
    sbq.push_back(s);
    ac_valid = 1; snoop = v.snoop; addr = v.addr;
    @(posedge clk); #1;              // edge E
    ac_valid = 0;
    t_cr = -1; t_cd = -1; t_last = -1; t_pass = -1; t_done = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (o_crvalid && t_cr < 0) t_cr = k;
      if (o_cdvalid && t_cd < 0) begin
        t_cd = k;
        chk({v.nm, "_data"}, o_cddata, {4{fill}});
      end
      if (o_cdlast && t_last < 0) t_last = k;
      if (o_pass && t_pass < 0) t_pass = k;
      if (o_done) begin t_done = k; break; end
      if (t_pass >= 0) break;
    end
    if (v.pass) begin
      chk_i({v.nm, "_t_pass"}, t_pass, 1);
      chk_i({v.nm, "_t_cr"}, t_cr, -1);
      chk_i({v.nm, "_t_done"}, t_done, -1);
    end else begin
      te     = (!v.resp[0] && v.test[1]) ? 2'b00 : v.test;
      e_cr   = 2 + ((te == 2'b01) ? v.n : 0);
      e_cd   = v.resp[0] ? 2 + ((te == 2'b10) ? v.n : 0) : -1;
      e_last = v.resp[0] ? 2 + (te[1] ? v.n : 0) : -1;
      mx     = (e_cr > e_last) ? e_cr : e_last;
      chk_i({v.nm, "_t_cr"}, t_cr, e_cr);
      chk_i({v.nm, "_t_cd"}, t_cd, e_cd);
      chk_i({v.nm, "_t_last"}, t_last, e_last);
      chk_i({v.nm, "_t_done"}, t_done, mx + 2);
    end
    chk({v.nm, "_fired"}, o_fired, v.fired);
    @(posedge clk); #1;
    chk({v.nm, "_idle"}, {o_pass, o_done, o_busy, o_crvalid, o_cdvalid}, 5'b0);
  endtask

  // ------------------------------------------------------------ main
  initial begin
    logic [127:0] c_prio, c_os, w_b, w_s;
    c_prio = {32'h0, mk(1,0,2'd0,5'h05,1,1,4'h7), 32'h0, mk(1,0,2'd0,5'h03,1,1,4'h7)};
    c_os   = {32'h0, mk(1,0,2'd0,5'h05,1,1,4'h7), 32'h0, mk(1,1,2'd0,5'h03,1,1,4'h7)};
    w_b    = {32'h0, 32'h1000, 32'h0, 32'h1000};
    w_s    = {32'h0, 32'h100,  32'h0, 32'h100};

    addv("imm", 1, {96'h0, mk(1,0,2'd0,5'h01,0,0,0)}, '0, '0, '0, 4'h0, 44'h123,
         0, 0, 5'h01, 2'd0, 0, 4'b0001);
    addv("dlycr", 1, {64'h0, mk(1,0,2'd1,5'h01,0,0,0), 32'h0}, '0, '0,
         {32'h0, 16'd2, 16'd0}, 4'h0, 44'h40, 0, 1, 5'h01, 2'd1, 300, 4'b0010);
    addv("prio", 1, c_prio, w_b, w_s, '0, 4'h7, 44'h1080, 0, 0, 5'h03, 2'd0, 0, 4'b0001);
    addv("os1", 1, c_os, w_b, w_s, '0, 4'h7, 44'h1080, 0, 0, 5'h03, 2'd0, 0, 4'b0001);
    addv("os2", 0, c_os, w_b, w_s, '0, 4'h7, 44'h1080, 0, 2, 5'h05, 2'd0, 0, 4'b0101);
    addv("snpmiss", 1, c_os, w_b, w_s, '0, 4'h6, 44'h1080, 1, 0, 5'h00, 2'd0, 0, 4'b0000);
    addv("below", 1, c_prio, w_b, w_s, '0, 4'h7, 44'h0FFF, 1, 0, 5'h00, 2'd0, 0, 4'b0000);
    addv("bound", 1, {96'h0, mk(1,0,2'd0,5'h01,0,1,0)}, {96'h0, 32'h2000},
         {96'h0, 32'h100}, '0, 4'h0, 44'h2100, 1, 0, 5'h00, 2'd0, 0, 4'b0000);
    addv("inb", 1, {96'h0, mk(1,0,2'd0,5'h01,0,1,0)}, {96'h0, 32'h2000},
         {96'h0, 32'h100}, '0, 4'h0, 44'h20FF, 0, 0, 5'h01, 2'd0, 0, 4'b0001);
    addv("top", 1, {96'h0, mk(1,0,2'd0,5'h01,0,1,0)}, {96'h0, 32'hFFFF_F000},
         {96'h0, 32'h1000}, '0, 4'h0, 44'h0_FFFF_FFFF, 0, 0, 5'h01, 2'd0, 0, 4'b0001);
    addv("dlycd", 1, {mk(1,0,2'd2,5'h01,0,0,0), 96'h0}, '0, '0, {16'd1, 48'h0},
         4'h0, 44'h0, 0, 3, 5'h01, 2'd2, 150, 4'b1000);
    addv("dlylast", 1, {64'h0, mk(1,0,2'd3,5'h09,0,0,0), 32'h0}, '0, '0,
         {32'h0, 16'd1, 16'd0}, 4'h0, 44'h0, 0, 1, 5'h09, 2'd3, 150, 4'b0010);
    addv("nodata", 1, {96'h0, mk(1,0,2'd2,5'h02,0,0,0)}, '0, '0, {48'h0, 16'd1},
         4'h0, 44'h0, 0, 0, 5'h02, 2'd2, 150, 4'b0001);
    addv("zerodly", 1, {96'h0, mk(1,0,2'd1,5'h01,0,0,0)}, '0, '0, '0,
         4'h0, 44'h0, 0, 0, 5'h01, 2'd1, 0, 4'b0001);
    addv("disabled", 1, '0, '0, '0, '0, 4'h0, 44'h0, 1, 0, 5'h00, 2'd0, 0, 4'b0000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {o_crvalid, o_cdvalid, o_cdlast, o_busy, o_pass, o_done,
                       o_hit_rule, o_fired, o_crresp}, '0);
    chk("reset_data", o_cddata, '0);
    rst = 0;
    @(posedge clk); #1;

    foreach (vt[i]) run_vec(vt[i]);

    // No data phase, CD-delay test, CR backpressure for 5 cycles
    cfg = {96'h0, mk(1,0,2'd2,5'h00,0,0,0)}; dly = {48'h0, 16'd3};
    base = '0; size = '0; crready = 0; cdready = 1; fclr = '1;
    @(posedge clk); #1;
    fclr = '0;
    sb_e.pass = 0; sb_e.hit = 0; sb_e.resp = 5'h00; sbq.push_back(sb_e);
    ac_valid = 1; snoop = 0; addr = 0;
    @(posedge clk); #1;
    ac_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_issue", {o_crvalid, o_cdvalid, o_cdlast}, 3'b100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {o_crvalid, o_cdvalid, o_cdlast, o_done}, 4'b1000);
    end
    crready = 1;
    @(posedge clk); #1;
    chk("bp_accept", {o_crvalid, o_done}, 2'b00);
    @(posedge clk); #1;
    chk("bp_done", {o_done, o_fired}, {1'b1, 4'b0001});
    @(posedge clk); #1;

    // Reset during DELAY
    cfg = {64'h0, mk(1,0,2'd1,5'h01,0,0,0), 32'h0}; dly = {32'h0, 16'd2, 16'd0};
    crready = 1; cdready = 0;
    sb_e.pass = 0; sb_e.hit = 1; sb_e.resp = 5'h01; sbq.push_back(sb_e);
    ac_valid = 1;
    @(posedge clk); #1;
    ac_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_pre", {o_busy, o_cdvalid, o_cdlast, o_crvalid}, 4'b1110);
    #2 rst = 1;
    #1;
    chk("rst_async", {o_crvalid, o_cdvalid, o_cdlast, o_busy, o_pass, o_done,
                      o_hit_rule, o_fired, o_crresp}, '0);
    chk("rst_async_data", o_cddata, '0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("rst_fired", o_fired, 4'b0000);
    run_vec(vt[0]);

    chk_i("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

endmodule
`default_nettype wire
